// File: rtl/cell_tester.sv
`default_nettype none
// ============================================================================
//  Module   : cell_tester
//  Purpose  : Exhaustive truth-table tester for one RV523 discrete logic cell.
//             Drives every input vector of the selected cell, holds it for
//             SETTLE_CYCLES clocks, samples the cell output through a 2-flop
//             synchroniser and compares it with the cell's Boolean function.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk           in   1  system clock, rising edge
//    rst           in   1  asynchronous active-high reset
//    start_i       in   1  begin a sweep (sampled in IDLE only)
//    cell_sel_i    in   4  cell code 0..10 (11..15 invalid)
//    dut_y_i       in   1  cell output, asynchronous to clk
//    dut_a_o       out  4  cell input drive, pin declaration order
//    busy_o        out  1  sweep in progress
//    done_o        out  1  one-cycle pulse at sweep end
//    pass_o        out  1  last sweep clean and cell code valid
//    bad_sel_o     out  1  last accepted start used an invalid cell code
//    err_count_o   out  5  mismatches in last sweep (0..16)
//    first_fail_o  out  4  vector of first mismatch (valid if err_count_o!=0)
//
//  Build option
//    CELL_TESTER_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//                                  sweep on the following edge.
// ============================================================================
module cell_tester #(
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [3:0] cell_sel_i,
    input  logic       dut_y_i,
    output logic [3:0] dut_a_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic       bad_sel_o,
    output logic [4:0] err_count_o,
    output logic [3:0] first_fail_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [7:0] C_LAST_CNT = 8'(SETTLE_CYCLES - 1);

    // Library Boolean function of each cell, inputs in pin declaration order.
    function automatic logic cell_fn(input logic [3:0] sel, input logic [3:0] a);
        logic y;
        case (sel)
            4'd0:    y = ~a[0];                                  // NOT
            4'd1:    y = ~(a[0] & a[1]);                         // NAND2
            4'd2:    y = ~(a[0] | a[1]);                         // NOR2
            4'd3:    y = ~(a[0] & a[1] & a[2]);                  // NAND3
            4'd4:    y = ~(a[0] | a[1] | a[2]);                  // NOR3
            4'd5:    y = ~(a[0] | (a[1] & a[2]));                // AOI21
            4'd6:    y = ~(a[0] & (a[1] | a[2]));                // OAI21
            4'd7:    y = ~((a[0] & a[1]) | (a[2] & a[3]));       // AOI22
            4'd8:    y = ~((a[0] | a[1]) & (a[2] | a[3]));       // OAI22
            4'd9:    y = ~(a[0] | a[1] | (a[2] & a[3]));         // AOI211
            4'd10:   y = ~(a[0] & a[1] & (a[2] | a[3]));         // OAI211
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    // Number of inputs of each cell; 0 marks an invalid code.
    function automatic logic [2:0] cell_width(input logic [3:0] sel);
        logic [2:0] k;
        case (sel)
            4'd0:                      k = 3'd1;
            4'd1, 4'd2:                k = 3'd2;
            4'd3, 4'd4, 4'd5, 4'd6:    k = 3'd3;
            4'd7, 4'd8, 4'd9, 4'd10:   k = 3'd4;
            default:                   k = 3'd0;
        endcase
        return k;
    endfunction

    state_t     state_q;
    logic [3:0] sel_q;
    logic [2:0] k_q;
    logic [3:0] vec_q;
    logic [7:0] cnt_q;
    logic       sync1_q;
    logic       sync2_q;
    logic [3:0] dut_a_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic       bad_sel_q;
    logic [4:0] err_count_q;
    logic [3:0] first_fail_q;
`ifdef CELL_TESTER_STOP_ON_FAIL_EN
    logic       stop_q;
`endif

    logic [3:0] last_vec_d;
    logic [3:0] vec_d;
    logic [3:0] dut_a_d;
    logic       mismatch_d;
    logic [4:0] err_count_d;

    always_comb begin
        // last_vec_d doubles as the k-bit mask for the drive value.
        last_vec_d  = 4'((5'd1 << k_q) - 5'd1);
        vec_d       = vec_q + 4'd1;
        dut_a_d     = vec_d & last_vec_d;
        mismatch_d  = (sync2_q != cell_fn(sel_q, vec_q));
        err_count_d = mismatch_d ? (err_count_q + 5'd1) : err_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= 4'd0;
            k_q          <= 3'd0;
            vec_q        <= 4'd0;
            cnt_q        <= 8'd0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            dut_a_q      <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            bad_sel_q    <= 1'b0;
            err_count_q  <= 5'd0;
            first_fail_q <= 4'd0;
`ifdef CELL_TESTER_STOP_ON_FAIL_EN
            stop_q       <= 1'b0;
`endif
        end else begin
            sync1_q <= dut_y_i;
            sync2_q <= sync1_q;

            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        sel_q        <= cell_sel_i;
                        k_q          <= cell_width(cell_sel_i);
                        vec_q        <= 4'd0;
                        cnt_q        <= 8'd0;
                        dut_a_q      <= 4'd0;
                        err_count_q  <= 5'd0;
                        first_fail_q <= 4'd0;
                        pass_q       <= 1'b0;
`ifdef CELL_TESTER_STOP_ON_FAIL_EN
                        stop_q       <= 1'b0;
`endif
                        if (cell_width(cell_sel_i) != 3'd0) begin
                            bad_sel_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end else begin
                            // Invalid code: report straight away, never busy.
                            bad_sel_q <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_FINISH;
                        end
                    end
                end

                S_RUN: begin
`ifdef CELL_TESTER_STOP_ON_FAIL_EN
                    if (stop_q) begin
                        stop_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dut_a_q <= 4'd0;
                        pass_q  <= (err_count_q == 5'd0) && !bad_sel_q;
                        state_q <= S_FINISH;
                    end else
`endif
                    if (cnt_q == C_LAST_CNT) begin
                        cnt_q       <= 8'd0;
                        err_count_q <= err_count_d;
                        if (mismatch_d && (err_count_q == 5'd0)) begin
                            first_fail_q <= vec_q;
                        end
                        vec_q <= vec_d;
                        if (vec_q == last_vec_d) begin
                            // Last vector compared: pass uses the updated count.
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dut_a_q <= 4'd0;
                            pass_q  <= (err_count_d == 5'd0) && !bad_sel_q;
                            state_q <= S_FINISH;
                        end else begin
                            dut_a_q <= dut_a_d;
`ifdef CELL_TESTER_STOP_ON_FAIL_EN
                            if (mismatch_d) begin
                                stop_q <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    dut_a_q <= 4'd0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_a_o      = dut_a_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign bad_sel_o    = bad_sel_q;
    assign err_count_o  = err_count_q;
    assign first_fail_o = first_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_cell_tester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cell_tester
//  Purpose  : Self-checking bench for cell_tester. A behavioural cell model
//             (correct, stuck-0, inverted, stuck-1) drives dut_y; a table of
//             sweeps with hand-computed results is applied, followed by
//             invalid-code and mid-sweep reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cell_tester;

    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] sel;
    logic       y;
    logic [3:0] dut_a;
    logic       busy;
    logic       done;
    logic       pass;
    logic       bad_sel;
    logic [4:0] err_count;
    logic [3:0] first_fail;

    logic [3:0] model_sel;
    logic [1:0] model_mode;   // 0 correct, 1 stuck-0, 2 inverted, 3 stuck-1

    int total  = 0;
    int passed = 0;

    cell_tester #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .cell_sel_i   (sel),
        .dut_y_i      (y),
        .dut_a_o      (dut_a),
        .busy_o       (busy),
        .done_o       (done),
        .pass_o       (pass),
        .bad_sel_o    (bad_sel),
        .err_count_o  (err_count),
        .first_fail_o (first_fail)
    );

    always #5 clk = ~clk;

    function automatic logic ref_fn(input logic [3:0] c, input logic [3:0] a);
        case (c)
            4'd0:    return !a[0];
            4'd1:    return !(a[0] && a[1]);
            4'd2:    return !(a[0] || a[1]);
            4'd3:    return !(a[0] && a[1] && a[2]);
            4'd4:    return !(a[0] || a[1] || a[2]);
            4'd5:    return !(a[0] || (a[1] && a[2]));
            4'd6:    return !(a[0] && (a[1] || a[2]));
            4'd7:    return !((a[0] && a[1]) || (a[2] && a[3]));
            4'd8:    return !((a[0] || a[1]) && (a[2] || a[3]));
            4'd9:    return !(a[0] || a[1] || (a[2] && a[3]));
            4'd10:   return !(a[0] && a[1] && (a[2] || a[3]));
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        case (model_mode)
            2'd0:    y = ref_fn(model_sel, dut_a);
            2'd1:    y = 1'b0;
            2'd2:    y = !ref_fn(model_sel, dut_a);
            default: y = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [3:0] sel;
        logic [1:0] mode;
        int         err;
        int         ff;
        logic       pass;
        int         lat;
    } vec_t;

    vec_t tbl[13];

    // Runs one sweep; with poke set, start is pulsed (invalid code) mid-sweep.
    // With rst_at > 0 the sweep is cut by reset after that many cycles.
    task automatic run_sweep(input vec_t t, input bit poke, input int rst_at);
        int   exp_err;
        int   exp_lat;
        int   cyc;
        bit   seq_bad;
        bit   done_seen;
        exp_err = t.err;
        exp_lat = t.lat;
`ifdef CELL_TESTER_STOP_ON_FAIL_EN
        if (t.err != 0) begin
            exp_err = 1;
            exp_lat = (t.ff + 1) * S + 1;
        end
`endif
        model_sel  = t.sel;
        model_mode = t.mode;
        @(negedge clk);
        sel   = t.sel;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sel   = 4'd15;          // changes after acceptance must be ignored
        chk("busy_at_start", {31'd0, busy}, 32'd1);
        chk("dut_a_at_start", {28'd0, dut_a}, 32'd0);
        cyc       = 0;
        seq_bad   = 1'b0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 600) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (poke && cyc >= 10 && cyc < 13);
            if (rst_at > 0 && cyc == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_dut_a", {28'd0, dut_a}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_flags", {29'd0, done, pass, bad_sel}, 32'd0);
                chk("rst_counts", {23'd0, err_count, first_fail}, 32'd0);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    #1;
                    if (done) done_seen = 1'b1;
                end
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk);
                #1;
                if (done) done_seen = 1'b1;
                chk("rst_no_done", {31'd0, done_seen}, 32'd0);
                chk("rst_seq", {31'd0, seq_bad}, 32'd0);
                chk("rst_idle_busy", {31'd0, busy}, 32'd0);
                return;
            end
            if (done) done_seen = 1'b1;
            else if (dut_a !== 4'(cyc / S)) seq_bad = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        chk("latency", cyc, exp_lat);
        chk("dut_a_seq", {31'd0, seq_bad}, 32'd0);
        chk("dut_a_done", {28'd0, dut_a}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("err_count", {27'd0, err_count}, exp_err);
        chk("first_fail", {28'd0, first_fail}, t.ff);
        chk("pass", {31'd0, pass}, {31'd0, t.pass});
        chk("bad_sel", {31'd0, bad_sel}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("err_hold", {27'd0, err_count}, exp_err);
    endtask

    initial begin
        //          sel    mode  err ff  pass  latency
        tbl[0]  = '{4'd1,  2'd0, 0,  0,  1'b1, 32};    // NAND2 correct
        tbl[1]  = '{4'd7,  2'd1, 9,  0,  1'b0, 128};   // AOI22 stuck-0
        tbl[2]  = '{4'd0,  2'd2, 2,  0,  1'b0, 16};    // NOT inverted
        tbl[3]  = '{4'd0,  2'd0, 0,  0,  1'b1, 16};    // NOT correct
        tbl[4]  = '{4'd2,  2'd3, 3,  1,  1'b0, 32};    // NOR2 stuck-1
        tbl[5]  = '{4'd3,  2'd3, 1,  7,  1'b0, 64};    // NAND3 stuck-1
        tbl[6]  = '{4'd5,  2'd1, 3,  0,  1'b0, 64};    // AOI21 stuck-0
        tbl[7]  = '{4'd6,  2'd3, 3,  3,  1'b0, 64};    // OAI21 stuck-1
        tbl[8]  = '{4'd8,  2'd2, 16, 0,  1'b0, 128};   // OAI22 inverted
        tbl[9]  = '{4'd9,  2'd3, 13, 1,  1'b0, 128};   // AOI211 stuck-1
        tbl[10] = '{4'd10, 2'd0, 0,  0,  1'b1, 128};   // OAI211 correct
        tbl[11] = '{4'd4,  2'd1, 1,  0,  1'b0, 64};    // NOR3 stuck-0
        tbl[12] = '{4'd10, 2'd1, 13, 0,  1'b0, 128};   // OAI211 stuck-0

        rst        = 1'b1;
        start      = 1'b0;
        sel        = 4'd0;
        model_sel  = 4'd0;
        model_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut_a", {28'd0, dut_a}, 32'd0);
        chk("reset_flags", {28'd0, busy, done, pass, bad_sel}, 32'd0);
        chk("reset_counts", {23'd0, err_count, first_fail}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_sweep(tbl[i], (i == 0), 0);
            repeat (2) @(posedge clk);
        end

        // Invalid cell code, then a clean sweep must clear bad_sel.
        @(negedge clk);
        sel   = 4'd12;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("inv_done", {31'd0, done}, 32'd1);
        chk("inv_bad_sel", {31'd0, bad_sel}, 32'd1);
        chk("inv_busy", {31'd0, busy}, 32'd0);
        chk("inv_pass", {31'd0, pass}, 32'd0);
        @(posedge clk);
        #1;
        chk("inv_done_pulse", {31'd0, done}, 32'd0);
        chk("inv_busy2", {31'd0, busy}, 32'd0);
        chk("inv_bad_hold", {31'd0, bad_sel}, 32'd1);
        run_sweep(tbl[3], 1'b0, 0);

        // OAI211 sweep with start pokes while busy, reset at cycle 40.
        run_sweep(tbl[10], 1'b1, 40);
        // Tester must be usable again after the reset.
        run_sweep(tbl[0], 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
